// File: rtl/serial_right_shifter_if.sv
// Start/done handshake bundle for the serial right shifter.
// The requester side uses the master modport, the shifter uses the slave modport.
interface serial_right_shifter_if #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned SHAMT_W = 5
);
  logic               start;
  logic [WIDTH-1:0]   data_in;
  logic [SHAMT_W-1:0] shamt;
  logic               arith;
  logic [WIDTH-1:0]   data_out;
  logic               busy;
  logic               done;

  modport master (
    output start, data_in, shamt, arith,
    input  data_out, busy, done
  );

  modport slave (
    input  start, data_in, shamt, arith,
    output data_out, busy, done
  );
endinterface

// File: rtl/serial_right_shifter.sv
// Multi-cycle right shifter: one bit per clock, zero or sign fill, start/done handshake.
// Optional feature macro: SERIAL_RSHIFT_ARITH_EN enables sign fill from the arith input;
// without it the arith input is ignored and every shift is logical.
module serial_right_shifter #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned SHAMT_W = 5
) (
  input logic                  clk,
  input logic                  reset,
  serial_right_shifter_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e             state;
  logic [SHAMT_W-1:0] count;
  logic [WIDTH-1:0]   result;
  logic               busy_r;
  logic               done_r;
  logic               fill;
  logic               accept;

  // A new request is taken only when not shifting.
  assign accept = bus.start && (state != StShift);

`ifdef SERIAL_RSHIFT_ARITH_EN
  // Fill bit latched at start so every shift step replicates the original sign.
  always_ff @(posedge clk) begin
    if (reset) begin
      fill <= 1'b0;
    end else if (accept) begin
      fill <= bus.arith & bus.data_in[WIDTH-1];
    end
  end
`else
  logic unused_arith;
  assign unused_arith = bus.arith;
  assign fill         = 1'b0;
`endif

  // Control FSM and datapath with registered busy/done.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= StIdle;
      count  <= '0;
      result <= '0;
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      unique case (state)
        StIdle, StDone: begin
          if (bus.start) begin
            state  <= StShift;
            result <= bus.data_in;
            count  <= bus.shamt;
            busy_r <= 1'b1;
            done_r <= 1'b0;
          end else begin
            state  <= StIdle;
            busy_r <= 1'b0;
            done_r <= 1'b0;
          end
        end
        StShift: begin
          if (count != '0) begin
            // Shifting past WIDTH keeps injecting fill, so large amounts saturate.
            result <= {fill, result[WIDTH-1:1]};
            count  <= count - SHAMT_W'(1);
          end else begin
            state  <= StDone;
            busy_r <= 1'b0;
            done_r <= 1'b1;
          end
        end
        default: begin
          state  <= StIdle;
          busy_r <= 1'b0;
          done_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.data_out = result;
  assign bus.busy     = busy_r;
  assign bus.done     = done_r;

endmodule
